game_flow_ctrl: RTL and testbench

- Sequencing controller for the top-level game multiplexer. It owns the `progress` select (0 menu, 1 RNG, 2 morse, 3 freeze) that the mux uses to route an/seg/oled.
- Debounces and edge-detects the navigation buttons (btnL, btnR).
- Enforces the unlock order, so game k+1 is enterable only after game k is completed.
- Pulses a per-game restart on entry and returns to the menu on exit or on inactivity timeout.

---
 rtl/game_flow_ctrl_pkg.sv | 26 ++
 rtl/game_flow_ctrl_btn_debounce.sv | 45 ++++
 rtl/game_flow_ctrl.sv | 130 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared encodings for the game sequencing controller and its helpers.
package game_flow_ctrl_pkg;

  localparam int NUM_GAMES = 3;

  localparam logic [2:0] PROG_MENU   = 3'd0;
  localparam logic [2:0] PROG_RNG    = 3'd1;
  localparam logic [2:0] PROG_MORSE  = 3'd2;
  localparam logic [2:0] PROG_FREEZE = 3'd3;

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_ENTER = 2'd1,
    ST_PLAY  = 2'd2,
    ST_EXIT  = 2'd3
  } state_t;

  // One-hot game mask for a 1-based game number; 0 and values above
  // NUM_GAMES shift the bit out and give an all-zero mask.
  function automatic logic [NUM_GAMES-1:0] game_mask(input logic [2:0] sel);
    logic [NUM_GAMES-1:0] one;
    one = {{(NUM_GAMES-1){1'b0}}, 1'b1};
    return one << (sel - 3'd1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, tick-gated debounce and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_MS = 20,
  parameter int CNT_W  = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;

  // Synchronise, count consecutive differing ticked samples, flip the level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      if (tick_i) begin
        if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q >= CNT_W'(DEB_MS - 1)) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
          pulse_q <= ~level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: owns the mux select, unlock order, per-game
// restart pulses and the inactivity timeout.
//
// state | meaning
// MENU  | progress=0, wait for a valid btnR selection
// ENTER | one cycle, restart pulse to the selected game, timeout cleared
// PLAY  | game owns the display; btnL or timeout leaves
// EXIT  | one cycle, progress already back to 0, then MENU
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int DEB_MS     = 20,
  parameter int TIMEOUT_MS = 30000,
  parameter int CNT_W      = 16
) (
  input  logic       basys_clock,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       btnL,
  input  logic       btnR,
  input  logic [2:0] menu_sel,
  input  logic       activity,
  input  logic [2:0] game_done,
  output logic [2:0] progress,
  output logic [2:0] game_rst,
  output logic [2:0] unlocked,
  output logic       all_done,
  output logic       err_locked
);

  logic             p_l;
  logic             p_r;
  state_t           state_q;
  logic [2:0]       sel_q;
  logic [2:0]       progress_q;
  logic [2:0]       game_rst_q;
  logic             err_q;
  logic [2:0]       done_q;
  logic [CNT_W-1:0] tmo_q;

  logic [2:0]       unlock_vec;
  logic             sel_ok;
  logic [CNT_W-1:0] tmo_inc;
  logic             tmo_hit;

  btn_debounce #(.DEB_MS(DEB_MS), .CNT_W(CNT_W)) u_deb_l (
    .clk_i   (basys_clock),
    .rst_i   (reset),
    .tick_i  (tick_1ms),
    .btn_i   (btnL),
    .pulse_o (p_l)
  );

  btn_debounce #(.DEB_MS(DEB_MS), .CNT_W(CNT_W)) u_deb_r (
    .clk_i   (basys_clock),
    .rst_i   (reset),
    .tick_i  (tick_1ms),
    .btn_i   (btnR),
    .pulse_o (p_r)
  );

  // Unlock chain, selection validity and the saturating timeout step.
  always_comb begin
    unlock_vec = {done_q[1], done_q[0], 1'b1};
    sel_ok     = (menu_sel != 3'd0) && (menu_sel <= 3'(NUM_GAMES)) &&
                 ((unlock_vec & game_mask(menu_sel)) != 3'b000);
    tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
    tmo_hit    = (TIMEOUT_MS != 0) && tick_1ms && !activity &&
                 (tmo_inc >= CNT_W'(TIMEOUT_MS));
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state_q    <= ST_MENU;
      sel_q      <= PROG_MENU;
      progress_q <= PROG_MENU;
      game_rst_q <= 3'b000;
      err_q      <= 1'b0;
      done_q     <= 3'b000;
      tmo_q      <= '0;
    end else begin
      game_rst_q <= 3'b000;
      err_q      <= 1'b0;
      case (state_q)
        ST_MENU: begin
          progress_q <= PROG_MENU;
          if (p_r) begin
            if (sel_ok) begin
              sel_q      <= menu_sel;
              progress_q <= menu_sel;
              game_rst_q <= game_mask(menu_sel);
              state_q    <= ST_ENTER;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ENTER: begin
          tmo_q   <= '0;
          state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          done_q <= done_q | (game_done & game_mask(sel_q));
          if (activity) begin
            tmo_q <= '0;
          end else if (tick_1ms) begin
            tmo_q <= tmo_inc;
          end
          if (p_l || tmo_hit) begin
            progress_q <= PROG_MENU;
            state_q    <= ST_EXIT;
          end
        end
        ST_EXIT: begin
          progress_q <= PROG_MENU;
          state_q    <= ST_MENU;
        end
        default: state_q <= ST_MENU;
      endcase
    end
  end

  assign progress   = progress_q;
  assign game_rst   = game_rst_q;
  assign err_locked = err_q;
  assign unlocked   = unlock_vec;
  assign all_done   = &done_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with an event scoreboard on the outputs.
module tb_game_flow_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 10;

  localparam logic [1:0] EV_PROG = 2'd0;
  localparam logic [1:0] EV_RST  = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  logic       basys_clock = 1'b0;
  logic       reset       = 1'b1;
  logic       tick_1ms    = 1'b0;
  logic       btnL        = 1'b0;
  logic       btnR        = 1'b0;
  logic [2:0] menu_sel    = 3'd1;
  logic       activity    = 1'b1;
  logic [2:0] game_done   = 3'b000;
  logic [2:0] progress;
  logic [2:0] game_rst;
  logic [2:0] unlocked;
  logic       all_done;
  logic       err_locked;

  int         checks   = 0;
  int         failures = 0;
  int         tcnt     = 0;
  bit         mon_en   = 1'b0;
  logic [2:0] prog_prev = 3'd0;
  logic [4:0] exp_q[$];

  game_flow_ctrl #(.DEB_MS(DEB), .TIMEOUT_MS(TMO), .CNT_W(16)) dut (
    .basys_clock (basys_clock),
    .reset       (reset),
    .tick_1ms    (tick_1ms),
    .btnL        (btnL),
    .btnR        (btnR),
    .menu_sel    (menu_sel),
    .activity    (activity),
    .game_done   (game_done),
    .progress    (progress),
    .game_rst    (game_rst),
    .unlocked    (unlocked),
    .all_done    (all_done),
    .err_locked  (err_locked)
  );

  always #5 basys_clock = ~basys_clock;

  // 1 ms tick stand-in: one cycle high out of every ten.
  always @(negedge basys_clock) begin
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    tick_1ms = (tcnt == 9);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [1:0] kind, input logic [2:0] val);
    exp_q.push_back({kind, val});
  endtask

  task automatic sb_check(input logic [1:0] kind, input logic [2:0] val);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_unexpected observed=%0h expected=none", {kind, val});
    end else begin
      e = exp_q.pop_front();
      chk("sb_event", {27'd0, kind, val}, {27'd0, e});
    end
  endtask

  // Output monitor: every pulse and every progress change is an event.
  always @(negedge basys_clock) begin
    if (mon_en) begin
      if (game_rst !== 3'b000) sb_check(EV_RST, game_rst);
      if (progress !== prog_prev) begin
        sb_check(EV_PROG, progress);
        prog_prev = progress;
      end
      if (err_locked !== 1'b0) sb_check(EV_ERR, {2'b00, err_locked});
    end
  end

  task automatic wait_tick();
    @(posedge basys_clock);
    while (tick_1ms !== 1'b1) @(posedge basys_clock);
  endtask

  // Hold the chosen buttons for n ticked samples, then release and let it settle.
  task automatic press(input bit l, input bit r, input int n);
    wait_tick();
    @(negedge basys_clock);
    btnL = l;
    btnR = r;
    repeat (n) wait_tick();
    @(negedge basys_clock);
    btnL = 1'b0;
    btnR = 1'b0;
    repeat (DEB + 1) wait_tick();
  endtask

  task automatic drive_sample(input bit v);
    @(negedge basys_clock);
    btnR = v;
    wait_tick();
  endtask

  task automatic enter_game(input logic [2:0] g);
    logic [2:0] m;
    m = 3'b001 << (g - 3'd1);
    menu_sel = g;
    exp_push(EV_RST, m);
    exp_push(EV_PROG, g);
    press(1'b0, 1'b1, 6);
  endtask

  task automatic exit_game();
    exp_push(EV_PROG, 3'd0);
    press(1'b1, 1'b0, 6);
  endtask

  task automatic pulse_done(input logic [2:0] v);
    @(negedge basys_clock);
    game_done = v;
    @(negedge basys_clock);
    game_done = 3'b000;
  endtask

  initial begin
    repeat (3) @(posedge basys_clock);
    @(negedge basys_clock);
    reset = 1'b0;
    chk("rst_progress", progress, 3'd0);
    chk("rst_game_rst", game_rst, 3'b000);
    chk("rst_unlocked", unlocked, 3'b001);
    chk("rst_all_done", all_done, 1'b0);
    chk("rst_err", err_locked, 1'b0);
    mon_en = 1'b1;

    // Long hold enters game 1 exactly once.
    menu_sel = 3'd1;
    exp_push(EV_RST, 3'b001);
    exp_push(EV_PROG, 3'd1);
    press(1'b0, 1'b1, 12);
    chk("enter1_progress", progress, 3'd1);
    chk("enter1_drained", exp_q.size(), 0);
    exit_game();
    chk("exit1_progress", progress, 3'd0);

    // Locked and invalid selections.
    menu_sel = 3'd2;
    exp_push(EV_ERR, 3'd1);
    press(1'b0, 1'b1, 6);
    chk("locked_progress", progress, 3'd0);
    menu_sel = 3'd0;
    exp_push(EV_ERR, 3'd1);
    press(1'b0, 1'b1, 6);
    chk("invalid_drained", exp_q.size(), 0);

    // Complete game 1; non-selected done bits ignored.
    enter_game(3'd1);
    pulse_done(3'b010);
    chk("ignored_done", unlocked, 3'b001);
    pulse_done(3'b001);
    exit_game();
    chk("unlock_after_g1", unlocked, 3'b011);

    // Glitch: 3 ticked samples high is not enough.
    menu_sel = 3'd1;
    press(1'b0, 1'b1, 3);
    chk("glitch_progress", progress, 3'd0);
    chk("glitch_drained", exp_q.size(), 0);

    // Bounce 1,0,1,1,1,1: a single pulse after the fourth stable sample.
    wait_tick();
    exp_push(EV_RST, 3'b001);
    exp_push(EV_PROG, 3'd1);
    drive_sample(1'b1);
    drive_sample(1'b0);
    drive_sample(1'b1);
    drive_sample(1'b1);
    drive_sample(1'b1);
    repeat (3) @(posedge basys_clock);
    #1 chk("bounce_early", progress, 3'd0);
    drive_sample(1'b1);
    repeat (3) @(posedge basys_clock);
    #1 chk("bounce_enter", progress, 3'd1);
    @(negedge basys_clock);
    btnR = 1'b0;
    repeat (DEB + 1) wait_tick();
    exit_game();

    // Inactivity timeout after exactly TMO ticks.
    enter_game(3'd1);
    wait_tick();
    @(negedge basys_clock);
    activity = 1'b0;
    exp_push(EV_PROG, 3'd0);
    repeat (TMO - 1) wait_tick();
    #1 chk("tmo_before", progress, 3'd1);
    wait_tick();
    @(negedge basys_clock);
    chk("tmo_exit", progress, 3'd0);
    activity = 1'b1;
    repeat (3) @(posedge basys_clock);

    // Activity on tick 9 restarts the count.
    enter_game(3'd1);
    wait_tick();
    @(negedge basys_clock);
    activity = 1'b0;
    repeat (8) wait_tick();
    @(negedge basys_clock);
    activity = 1'b1;
    wait_tick();
    @(negedge basys_clock);
    activity = 1'b0;
    repeat (6) wait_tick();
    #1 chk("tmo_restart", progress, 3'd1);
    activity = 1'b1;
    exit_game();

    // Games 2 and 3, then reset mid-PLAY(3).
    enter_game(3'd2);
    pulse_done(3'b010);
    exit_game();
    chk("unlock_after_g2", unlocked, 3'b111);
    enter_game(3'd3);
    pulse_done(3'b100);
    chk("all_done_set", all_done, 1'b1);
    exp_push(EV_PROG, 3'd0);
    @(negedge basys_clock);
    reset = 1'b1;
    @(posedge basys_clock);
    #1;
    chk("midrst_progress", progress, 3'd0);
    chk("midrst_unlocked", unlocked, 3'b001);
    chk("midrst_all_done", all_done, 1'b0);
    @(negedge basys_clock);
    reset = 1'b0;

    // Simultaneous pL/pR: PLAY honours pL, MENU honours pR.
    enter_game(3'd1);
    pulse_done(3'b001);
    exit_game();
    enter_game(3'd2);
    exp_push(EV_PROG, 3'd0);
    press(1'b1, 1'b1, 6);
    chk("both_play_exit", progress, 3'd0);
    menu_sel = 3'd1;
    exp_push(EV_RST, 3'b001);
    exp_push(EV_PROG, 3'd1);
    press(1'b1, 1'b1, 6);
    chk("both_menu_enter", progress, 3'd1);

    repeat (5) @(posedge basys_clock);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
